// File: rtl/ksa4_pulse_checker.sv
// ksa4_pulse_checker: checks a pulse-encoded 4-bit adder.
//   Each cycle with en_Pad high offers one vector (a, b, cin). A high pad
//   means 1 and an absent pulse means 0. The expected 5-bit sum travels down
//   a LATENCY-deep shift line. When the entry leaves the line, it is compared
//   with the result pulses (sum3..sum0, cout) seen in that same cycle.
//
// Parameters:
//   LATENCY  cycles from operand pulse to result pulse (1..8)
//   CNT_W    width of vec_count / err_count / first_err_idx
//
// Ports:
//   GCLK_Pad            clock
//   rst_Pad             synchronous active-high reset
//   en_Pad              level; vectors are offered while high
//   a0..a3, b0..b3,
//   cin _Pad            operand pulses
//   sum0..sum3,
//   cout _Pad           result pulses
//   err_Pad             one-cycle pulse per mismatch (cycle after the compare)
//   busy_Pad            high whenever the FSM is not in IDLE
//   vec_count           saturating count of compared vectors
//   err_count           saturating count of mismatches
//   first_err_exp/got/idx  capture of the first mismatch after reset
//
// Optional feature macro: KSA4_CHK_FIRST_ERR_EN enables the first-mismatch
// capture. Without it, the first_err_* ports are tied to zero.

module ksa4_pulse_checker #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             GCLK_Pad,
  input  logic             rst_Pad,
  input  logic             en_Pad,
  input  logic             a0_Pad,
  input  logic             a1_Pad,
  input  logic             a2_Pad,
  input  logic             a3_Pad,
  input  logic             b0_Pad,
  input  logic             b1_Pad,
  input  logic             b2_Pad,
  input  logic             b3_Pad,
  input  logic             cin_Pad,
  input  logic             sum0_Pad,
  input  logic             sum1_Pad,
  input  logic             sum2_Pad,
  input  logic             sum3_Pad,
  input  logic             cout_Pad,
  output logic             err_Pad,
  output logic             busy_Pad,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [4:0]       first_err_exp,
  output logic [4:0]       first_err_got,
  output logic [CNT_W-1:0] first_err_idx
);

  localparam int unsigned RES_W  = 5;
  localparam int unsigned FILL_W = $clog2(LATENCY + 1);

  // Valid positions that still remain after the current exit entry leaves.
  localparam logic [LATENCY-1:0] KEEP_MASK =
    LATENCY'((32'd1 << (LATENCY - 1)) - 32'd1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CHECK = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t              state;
  logic [FILL_W-1:0]   fill_cnt;

  logic [RES_W-1:0]    line_exp [LATENCY];
  logic [LATENCY-1:0]  line_valid;

  logic [3:0]          a_c;
  logic [3:0]          b_c;
  logic [RES_W-1:0]    exp_c;
  logic [RES_W-1:0]    got_c;
  logic                push_c;
  logic                cmp_c;
  logic                mismatch_c;

  // Decode the pulse pads into operand and result words.
  assign a_c   = {a3_Pad, a2_Pad, a1_Pad, a0_Pad};
  assign b_c   = {b3_Pad, b2_Pad, b1_Pad, b0_Pad};
  assign got_c = {cout_Pad, sum3_Pad, sum2_Pad, sum1_Pad, sum0_Pad};

  // Full 5-bit sum, so the carry-out is never lost.
  assign exp_c = RES_W'(a_c) + RES_W'(b_c) + RES_W'(cin_Pad);

  // A vector offered in IDLE starts the FILL period. That makes it the first
  // FILL entry, so it is pushed as valid. A vector offered in DRAIN is ignored.
  assign push_c = en_Pad && (state != DRAIN);

  // Compare on the cycle the oldest entry leaves the line.
  assign cmp_c      = line_valid[LATENCY-1];
  assign mismatch_c = cmp_c && (got_c != line_exp[LATENCY-1]);

  // Shift line of expected values with a valid bit per entry.
  always_ff @(posedge GCLK_Pad) begin
    if (rst_Pad) begin
      line_valid <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        line_exp[i] <= '0;
      end
    end else begin
      line_valid[0] <= push_c;
      line_exp[0]   <= exp_c;
      for (int i = 1; i < LATENCY; i++) begin
        line_valid[i] <= line_valid[i-1];
        line_exp[i]   <= line_exp[i-1];
      end
    end
  end

  // Control FSM. busy_Pad is registered alongside the state.
  always_ff @(posedge GCLK_Pad) begin
    if (rst_Pad) begin
      state    <= IDLE;
      fill_cnt <= '0;
      busy_Pad <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en_Pad) begin
            state    <= FILL;
            fill_cnt <= '0;
            busy_Pad <= 1'b1;
          end
        end
        FILL: begin
          if (!en_Pad) begin
            state <= DRAIN;
          end else if (fill_cnt == FILL_W'(LATENCY - 1)) begin
            state <= CHECK;
          end else begin
            fill_cnt <= fill_cnt + FILL_W'(1);
          end
        end
        CHECK: begin
          if (!en_Pad) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // Leave once nothing valid will remain after this cycle's compare.
          if ((line_valid & KEEP_MASK) == '0) begin
            state    <= IDLE;
            busy_Pad <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          busy_Pad <= 1'b0;
        end
      endcase
    end
  end

  // Error pulse and saturating counters, all updated on the edge after the compare.
  always_ff @(posedge GCLK_Pad) begin
    if (rst_Pad) begin
      err_Pad   <= 1'b0;
      vec_count <= '0;
      err_count <= '0;
    end else begin
      err_Pad <= mismatch_c;
      if (cmp_c && (vec_count != '1)) begin
        vec_count <= vec_count + CNT_W'(1);
      end
      if (mismatch_c && (err_count != '1)) begin
        err_count <= err_count + CNT_W'(1);
      end
    end
  end

`ifdef KSA4_CHK_FIRST_ERR_EN
  logic first_seen;

  // Latch the first mismatch after reset; the index is the pre-increment vec_count.
  always_ff @(posedge GCLK_Pad) begin
    if (rst_Pad) begin
      first_seen    <= 1'b0;
      first_err_exp <= '0;
      first_err_got <= '0;
      first_err_idx <= '0;
    end else if (mismatch_c && !first_seen) begin
      first_seen    <= 1'b1;
      first_err_exp <= line_exp[LATENCY-1];
      first_err_got <= got_c;
      first_err_idx <= vec_count;
    end
  end
`else
  assign first_err_exp = '0;
  assign first_err_got = '0;
  assign first_err_idx = '0;
`endif

endmodule

// File: tb/tb_ksa4_pulse_checker.sv
// Directed bench for ksa4_pulse_checker. It uses the default instance
// (LATENCY=4, CNT_W=16) and a CNT_W=4 instance for counter saturation.
// Both instances share the same stimulus.

module tb_ksa4_pulse_checker;

`ifdef KSA4_CHK_FIRST_ERR_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  logic        GCLK_Pad = 1'b0;
  logic        rst_Pad  = 1'b1;
  logic        en_Pad   = 1'b0;
  logic [3:0]  a_v      = '0;
  logic [3:0]  b_v      = '0;
  logic        cin_Pad  = 1'b0;
  logic [4:0]  res_v    = '0;

  logic        err_Pad,  busy_Pad;
  logic [15:0] vec_count, err_count, first_err_idx;
  logic [4:0]  first_err_exp, first_err_got;

  logic        s_err, s_busy;
  logic [3:0]  s_vec, s_errc, s_idx;
  logic [4:0]  s_fexp, s_fgot;

  int tests = 0;
  int fails = 0;
  int err_seen = 0;
  int base;

  always #5 GCLK_Pad = ~GCLK_Pad;

  // Count err_Pad pulses on the main instance.
  always @(negedge GCLK_Pad) if (err_Pad) err_seen <= err_seen + 1;

  ksa4_pulse_checker #(.LATENCY(4), .CNT_W(16)) u_dut (
    .GCLK_Pad(GCLK_Pad), .rst_Pad(rst_Pad), .en_Pad(en_Pad),
    .a0_Pad(a_v[0]), .a1_Pad(a_v[1]), .a2_Pad(a_v[2]), .a3_Pad(a_v[3]),
    .b0_Pad(b_v[0]), .b1_Pad(b_v[1]), .b2_Pad(b_v[2]), .b3_Pad(b_v[3]),
    .cin_Pad(cin_Pad),
    .sum0_Pad(res_v[0]), .sum1_Pad(res_v[1]), .sum2_Pad(res_v[2]),
    .sum3_Pad(res_v[3]), .cout_Pad(res_v[4]),
    .err_Pad(err_Pad), .busy_Pad(busy_Pad),
    .vec_count(vec_count), .err_count(err_count),
    .first_err_exp(first_err_exp), .first_err_got(first_err_got),
    .first_err_idx(first_err_idx)
  );

  ksa4_pulse_checker #(.LATENCY(4), .CNT_W(4)) u_sat (
    .GCLK_Pad(GCLK_Pad), .rst_Pad(rst_Pad), .en_Pad(en_Pad),
    .a0_Pad(a_v[0]), .a1_Pad(a_v[1]), .a2_Pad(a_v[2]), .a3_Pad(a_v[3]),
    .b0_Pad(b_v[0]), .b1_Pad(b_v[1]), .b2_Pad(b_v[2]), .b3_Pad(b_v[3]),
    .cin_Pad(cin_Pad),
    .sum0_Pad(res_v[0]), .sum1_Pad(res_v[1]), .sum2_Pad(res_v[2]),
    .sum3_Pad(res_v[3]), .cout_Pad(res_v[4]),
    .err_Pad(s_err), .busy_Pad(s_busy),
    .vec_count(s_vec), .err_count(s_errc),
    .first_err_exp(s_fexp), .first_err_got(s_fgot),
    .first_err_idx(s_idx)
  );

  // One clock cycle: drive the inputs, then step to 1 time unit after the edge.
  task automatic cyc(input logic en, input logic [3:0] a, input logic [3:0] b,
                     input logic ci, input logic [4:0] res);
    en_Pad  = en;
    a_v     = a;
    b_v     = b;
    cin_Pad = ci;
    res_v   = res;
    @(posedge GCLK_Pad);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 4'h0, 1'b0, 5'h00);
  endtask

  task automatic do_reset();
    rst_Pad = 1'b1;
    idle(2);
    rst_Pad = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drain-test vectors and their hand-computed 5-bit sums.
  logic [3:0] ta [10] = '{4'h0, 4'hF, 4'h1, 4'h8, 4'h7, 4'hA, 4'h3, 4'hF, 4'hC, 4'h6};
  logic [3:0] tb [10] = '{4'h0, 4'hF, 4'h2, 4'h8, 4'h9, 4'h5, 4'h3, 4'h1, 4'h4, 4'h6};
  logic       tc [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [4:0] ts [10] = '{5'h00, 5'h1F, 5'h03, 5'h10, 5'h11, 5'h0F, 5'h07, 5'h10, 5'h11, 5'h0C};

  initial begin
    // Reset state
    do_reset();
    chk("rst_vec",  32'(vec_count), 32'd0);
    chk("rst_err",  32'(err_count), 32'd0);
    chk("rst_busy", 32'(busy_Pad),  32'd0);
    chk("rst_errp", 32'(err_Pad),   32'd0);
    chk("rst_fexp", 32'(first_err_exp), 32'd0);
    chk("rst_fidx", 32'(first_err_idx), 32'd0);

    // Pass case: a=1, b=5, cin=1 gives 7; result arrives 4 cycles later
    base = err_seen;
    cyc(1'b1, 4'h1, 4'h5, 1'b1, 5'h00);
    chk("pass_busy_hi", 32'(busy_Pad), 32'd1);
    idle(3);
    cyc(1'b0, 4'h0, 4'h0, 1'b0, 5'h07);
    idle(3);
    chk("pass_vec",  32'(vec_count), 32'd1);
    chk("pass_err",  32'(err_count), 32'd0);
    chk("pass_errp", 32'(err_seen - base), 32'd0);
    chk("pass_busy_lo", 32'(busy_Pad), 32'd0);

    // Stray result pulses in IDLE
    cyc(1'b0, 4'h0, 4'h0, 1'b0, 5'h11);
    idle(3);
    chk("stray_vec",  32'(vec_count), 32'd1);
    chk("stray_err",  32'(err_count), 32'd0);
    chk("stray_errp", 32'(err_seen - base), 32'd0);
    chk("stray_busy", 32'(busy_Pad), 32'd0);

    // Mismatch case: 0xB+0xE = 0x19; received 0x11
    do_reset();
    base = err_seen;
    cyc(1'b1, 4'hB, 4'hE, 1'b0, 5'h00);
    idle(3);
    cyc(1'b0, 4'h0, 4'h0, 1'b0, 5'h11);
    chk("mm_errp_hi", 32'(err_Pad), 32'd1);
    idle(1);
    chk("mm_errp_lo", 32'(err_Pad), 32'd0);
    idle(2);
    chk("mm_err",  32'(err_count), 32'd1);
    chk("mm_vec",  32'(vec_count), 32'd1);
    chk("mm_pulses", 32'(err_seen - base), 32'd1);
    chk("mm_fexp", 32'(first_err_exp), FE ? 32'h19 : 32'h0);
    chk("mm_fgot", 32'(first_err_got), FE ? 32'h11 : 32'h0);
    chk("mm_fidx", 32'(first_err_idx), 32'h0);

    // Drain case: 10 back-to-back vectors including 0+0+0, then en low
    do_reset();
    base = err_seen;
    for (int i = 0; i < 14; i++) begin
      cyc(i < 10, (i < 10) ? ta[i] : 4'h0, (i < 10) ? tb[i] : 4'h0,
          (i < 10) ? tc[i] : 1'b0, (i >= 4) ? ts[i-4] : 5'h00);
      if (i >= 9) chk($sformatf("drain_busy_%0d", i), 32'(busy_Pad), (i < 13) ? 32'd1 : 32'd0);
    end
    idle(2);
    chk("drain_vec",  32'(vec_count), 32'd10);
    chk("drain_err",  32'(err_count), 32'd0);
    chk("drain_errp", 32'(err_seen - base), 32'd0);

    // Reset on cycle 2 of CHECK, then apply wrong results
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1'b1, 4'h1, 4'h1, 1'b0, (i >= 4) ? 5'h02 : 5'h00);
    rst_Pad = 1'b1;
    cyc(1'b1, 4'h1, 4'h1, 1'b0, 5'h1F);
    rst_Pad = 1'b0;
    base = err_seen;
    for (int i = 0; i < 6; i++) cyc(1'b0, 4'h0, 4'h0, 1'b0, 5'h1F);
    chk("mrst_vec",  32'(vec_count), 32'd0);
    chk("mrst_err",  32'(err_count), 32'd0);
    chk("mrst_busy", 32'(busy_Pad), 32'd0);
    chk("mrst_errp", 32'(err_seen - base), 32'd0);

    // Saturation: 20 vectors a+0+0, each answered with cout wrongly set
    do_reset();
    base = err_seen;
    for (int i = 0; i < 24; i++) begin
      logic [3:0] av;
      logic [3:0] rv;
      av = 4'(i);
      rv = 4'(i - 4);
      cyc(i < 20, (i < 20) ? av : 4'h0, 4'h0, 1'b0, (i >= 4) ? {1'b1, rv} : 5'h00);
    end
    idle(2);
    chk("sat_vec",  32'(s_vec),  32'd15);
    chk("sat_err",  32'(s_errc), 32'd15);
    chk("wide_vec", 32'(vec_count), 32'd20);
    chk("wide_err", 32'(err_count), 32'd20);
    chk("wide_pulses", 32'(err_seen - base), 32'd20);
    chk("sat_fexp", 32'(first_err_exp), FE ? 32'h00 : 32'h0);
    chk("sat_fgot", 32'(first_err_got), FE ? 32'h10 : 32'h0);
    idle(4);
    chk("sat_hold_vec", 32'(s_vec),  32'd15);
    chk("sat_hold_err", 32'(s_errc), 32'd15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
